// File: rtl/uart_rx_io.sv
// 8N1 UART receiver with a 4-entry receive FIFO, sticky framing/overrun flags
// and a combinational head-of-FIFO view for the I/O port decoder.
`timescale 1ns/1ps
module uart_rx_io #(
    parameter int CLOCK = 50000000,
    parameter int BAUD  = 115200
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       uart_rx,
    input  logic       rd_pop,
    input  logic       clr_err,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       rx_ferr,
    output logic       rx_overrun,
    output logic       rx_busy
);

    localparam int DIV = CLOCK / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF   = CW'(DIV / 2 - 1);

    generate
        if (DIV < 4) begin : g_div_check
            $error("uart_rx_io: CLOCK/BAUD must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    logic [1:0]    sync_q;
    logic          rx_s;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bitcnt_q;
    logic [7:0]    shreg_q;
    logic          tick;

    logic [7:0]    mem_q [4];
    logic [1:0]    wr_ptr_q;
    logic [1:0]    rd_ptr_q;
    logic [2:0]    count_q;
    logic [2:0]    count_d;
    logic          ferr_q;
    logic          overrun_q;

    logic          push_ev;
    logic          ferr_ev;
    logic          full;
    logic          empty;
    logic          pop_ok;
    logic          push_ok;
    logic          ovr_ev;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], uart_rx};
        end
    end

    assign rx_s = sync_q[1];
    assign tick = (cnt_q == '0);

    // Timer runs in every non-idle state; START preloads half a bit so
    // each later tick lands mid-bit.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
        end else begin
            if (state_q != ST_IDLE) begin
                cnt_q <= tick ? CNT_RELOAD : cnt_q - 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_q <= ST_START;
                        cnt_q   <= CNT_HALF;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (rx_s) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q  <= ST_DATA;
                            bitcnt_q <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shreg_q  <= {rx_s, shreg_q[7:1]};
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (bitcnt_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        state_q <= rx_s ? ST_IDLE : ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign push_ev = (state_q == ST_STOP) && tick && rx_s;
    assign ferr_ev = (state_q == ST_STOP) && tick && !rx_s;

    assign full    = (count_q == 3'd4);
    assign empty   = (count_q == 3'd0);
    assign pop_ok  = rd_pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = push_ev && (!full || pop_ok);
    assign ovr_ev  = push_ev && full && !rd_pop;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mem
            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    mem_q[gi] <= '0;
                end else if (push_ok && (wr_ptr_q == 2'(gi))) begin
                    mem_q[gi] <= shreg_q;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (ferr_ev) begin
                ferr_q <= 1'b1;
            end else if (clr_err) begin
                ferr_q <= 1'b0;
            end
            if (ovr_ev) begin
                overrun_q <= 1'b1;
            end else if (clr_err) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign rx_data    = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign rx_ready   = !empty;
    assign rx_ferr    = ferr_q;
    assign rx_overrun = overrun_q;
    assign rx_busy    = (state_q != ST_IDLE);

endmodule
